flit_arbiter_rr: RTL and testbench
==================================

Name:
flit_arbiter_rr

Overview:
- Round-robin, packet-locking arbiter that shares one flit channel among N_SRC source2-style requesters.
- Grants one source at a time, holds the grant for a full packet of PKT_FLITS flits, then rotates priority.
- Sits between local sources and one router input port or sink2.
- Single-entry output register. Uses the codebase req/ack flit handshake on both sides.

Parameters:
- N_SRC, 4: number of requesting sources. Range 2..8.
- PKT_FLITS, 2: flits per packet. The grant is held for this many flits. Range 1..255.
- SIZE, `SIZE: flit width, taken from the shared constants.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_req  in  N_SRC  per-source request. Bit i corresponds to source i.
- in_ack  out  N_SRC  per-source accept pulse.
- in_data  in  N_SRC*SIZE  flattened flits. Source i occupies bits [i*SIZE +: SIZE].
- out_req  out  1  output flit valid.
- out_ack  in  1  downstream accept pulse.
- out_data  out  SIZE  output flit.
- lock_err  out  1  sticky watchdog error. Tied to 0 when the watchdog is compiled out.

Behaviour:
- Reset (reset low, asynchronous):
  - in_ack=0, out_req=0, out_data=0, lock_err=0.
  - State UNLOCKED, rr pointer ptr=0, flit counter cnt=0.
  - Any held flit is discarded. Assertion mid-packet abandons the packet; no partial state survives.
- Output register states:
  - EMPTY: out_req=0.
  - FULL: out_req=1.
  - out_data changes only on capture.
- Capture condition (rising edge): register EMPTY, grant g valid, in_req[g]=1.
  - Load in_data[g] into out_data; the register becomes FULL.
  - in_ack[g] is registered high for exactly the next cycle.
  - All other in_ack bits stay 0. At most one in_ack bit is high in any cycle.
- Drain: at an edge where FULL and out_ack=1, the register becomes EMPTY and out_req falls in the next cycle.
  - out_ack while EMPTY is ignored.
  - Capture and drain never occur on the same edge, so peak throughput is 1 flit per 2 cycles.
- Arbitration states:
  - UNLOCKED: g is the first i with in_req[i]=1, searching ptr, ptr+1, ... mod N_SRC.
    - On capture: go to LOCKED(g), cnt=1.
    - If PKT_FLITS==1, go straight to release instead.
  - LOCKED(g): only source g may be captured, even if g is idle and others request.
    - Each capture increments cnt.
    - The capture that makes cnt==PKT_FLITS triggers release.
  - Release: go to UNLOCKED, ptr=(g+1) mod N_SRC, cnt=0.
- The pointer update is visible to arbitration at the next capture opportunity.
- Requests from sources other than the grant are held pending; there is no loss.
- Sources must hold req/data stable until they see their ack, then present the next flit or drop req.
- An in_req drop without ack is tolerated only while the source is not granted.
- cnt is 8 bits, never exceeds PKT_FLITS, and never wraps.

Optional Feature:
- Macro: FLIT_ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit idle counter runs while LOCKED and in_req[g]=0. It clears on any capture.
  - At 16 idle cycles: force release (ptr=g+1 mod N_SRC, cnt=0) and set lock_err=1.
  - lock_err stays at 1 until reset.
- Undefined:
  - No counter is built, lock_err is constant 0, and the lock persists indefinitely.

Decomposition:
- Shared package/constants file (constants_2D.v):
  - `SIZE, and a new `BITS_SRC = clog2 of max N_SRC (3).
  - Arbiter state encodings ARB_UNLOCKED/ARB_LOCKED.
  - The watchdog limit `ARB_WD_LIMIT=16.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any.
- Lock FSM, counter and output register stay in flit_arbiter_rr.

Test Plan:
- Single source: src0 sends 2 flits 0x11, 0x22 with immediate out_ack → out_data 0x11 then 0x22. in_ack[0] pulses twice. State returns to UNLOCKED with ptr=1.
- Contention: src1 and src3 request together from reset (ptr=0) → src1 packet (2 flits) completes entirely before any src3 flit. ptr=2 after src1, then ptr=0 after src3.
- Packet lock: src0 gets flit 1 granted, then pauses 5 cycles while src2 requests → no src2 capture until src0's second flit. src2 is served next.
- Backpressure: hold out_ack=0 for 10 cycles → out_req stays 1, out_data stable, no in_ack pulses, no flit loss or duplication.
- Reset mid-packet: assert reset while FULL and LOCKED after 1 flit → out_req/in_ack drop immediately (asynchronous). After release, src0 arbitration restarts from ptr=0 with cnt=0.
- Watchdog (FLIT_ARB_WATCHDOG_EN): src2 locked after 1 flit then idles 16 cycles → lock_err=1, src3 is granted next. With the macro undefined, src3 is never granted and lock_err=0.

Source files
------------

// File: rtl/flit_arbiter_rr_pkg.sv
// Shared constants and types for the round-robin packet-locking flit arbiter.
package flit_arbiter_rr_pkg;

  localparam int SIZE_DEF     = 16;
  localparam int BITS_SRC     = 3;
  localparam int MAX_SRC      = 8;
  localparam int ARB_WD_LIMIT = 16;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

  // Successor of source s in a ring of n sources.
  function automatic logic [BITS_SRC-1:0] next_src(input logic [BITS_SRC-1:0] s,
                                                   input logic [BITS_SRC-1:0] last);
    return (s == last) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/flit_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import flit_arbiter_rr_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [BITS_SRC-1:0] ptr,
  output logic [N_SRC-1:0]    gnt,
  output logic [BITS_SRC-1:0] idx,
  output logic                any
);

  localparam logic [BITS_SRC:0] N_W = (BITS_SRC+1)'(N_SRC);

  logic [N_SRC-1:0]  rot;
  logic [BITS_SRC:0] sum;

  always_comb begin
    // rot[k] is the request of the source k places after ptr
    rot = N_SRC'({req, req} >> ptr);
    idx = '0;
    any = 1'b0;
    sum = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (BITS_SRC+1)'(k);
        idx = (sum >= N_W) ? BITS_SRC'(sum - N_W) : sum[BITS_SRC-1:0];
      end
    end
    gnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gnt[i] = any && (idx == BITS_SRC'(i));
    end
  end

endmodule

// File: rtl/flit_arbiter_rr.sv
// Round-robin arbiter that locks the grant for a whole packet of PKT_FLITS flits.
// Optional lock watchdog: define FLIT_ARB_WATCHDOG_EN.
module flit_arbiter_rr
  import flit_arbiter_rr_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int PKT_FLITS = 2,
  parameter int SIZE      = SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      in_req,
  output logic [N_SRC-1:0]      in_ack,
  input  logic [N_SRC*SIZE-1:0] in_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [SIZE-1:0]       out_data,
  output logic                  lock_err,
  output arb_state_e            dbg_state,
  output logic [BITS_SRC-1:0]   dbg_ptr,
  output logic [7:0]            dbg_cnt
);

  // Handshake (both sides): req/data are held until a one-cycle ack pulse; the
  // flit transfers at the edge that raises ack (input side) or that sees
  // out_req && out_ack (output side).

  localparam logic [7:0]          PKT_W = 8'(PKT_FLITS);
  localparam logic [BITS_SRC-1:0] LAST  = BITS_SRC'(N_SRC - 1);

  arb_state_e          state_q, state_d;
  logic [BITS_SRC-1:0] grant_q, grant_d;
  logic [BITS_SRC-1:0] ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [SIZE-1:0]     data_q, data_d;
  logic [N_SRC-1:0]    ack_q, ack_d;

  logic [MAX_SRC-1:0]  req_pad;
  logic [SIZE-1:0]     src_data [MAX_SRC];
  logic [N_SRC-1:0]    pick_gnt;
  logic [BITS_SRC-1:0] pick_idx;
  logic                pick_any;
  logic [BITS_SRC-1:0] cap_idx;
  logic                capture;
  logic [7:0]          cnt_inc;

  for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_pad
    if (gi < N_SRC) begin : g_src
      assign req_pad[gi]  = in_req[gi];
      assign src_data[gi] = in_data[gi*SIZE +: SIZE];
    end else begin : g_nil
      assign req_pad[gi]  = 1'b0;
      assign src_data[gi] = '0;
    end
  end

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req (in_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef FLIT_ARB_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    data_d  = data_q;
    ack_d   = '0;
    cnt_inc = cnt_q + 8'd1;
    cap_idx = (state_q == ARB_LOCKED) ? grant_q : pick_idx;
    capture = !full_q && ((state_q == ARB_LOCKED) ? req_pad[grant_q] : pick_any);

    if (full_q && out_ack) begin
      full_d = 1'b0;
    end

    if (capture) begin
      full_d = 1'b1;
      data_d = src_data[cap_idx];
      if (state_q == ARB_LOCKED) begin
        for (int i = 0; i < N_SRC; i++) begin
          ack_d[i] = (grant_q == BITS_SRC'(i));
        end
      end else begin
        ack_d = pick_gnt;
      end
      if (cnt_inc == PKT_W) begin
        state_d = ARB_UNLOCKED;
        ptr_d   = next_src(cap_idx, LAST);
        cnt_d   = '0;
      end else begin
        state_d = ARB_LOCKED;
        grant_d = cap_idx;
        cnt_d   = cnt_inc;
      end
    end

`ifdef FLIT_ARB_WATCHDOG_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (capture || state_q == ARB_UNLOCKED) begin
      wd_d = '0;
    end else if (!req_pad[grant_q]) begin
      // Owner went silent mid-packet: give up the lock after the limit
      if (wd_q == 8'(ARB_WD_LIMIT - 1)) begin
        wd_d    = '0;
        err_d   = 1'b1;
        state_d = ARB_UNLOCKED;
        ptr_d   = next_src(grant_q, LAST);
        cnt_d   = '0;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_UNLOCKED;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
`ifdef FLIT_ARB_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
`ifdef FLIT_ARB_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef FLIT_ARB_WATCHDOG_EN
  assign lock_err = err_q;
`else
  assign lock_err = 1'b0;
`endif

  assign in_ack    = ack_q;
  assign out_req   = full_q;
  assign out_data  = data_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_flit_arbiter_rr.sv
// Bench for flit_arbiter_rr: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a behavioural model.
module tb_flit_arbiter_rr;
  import flit_arbiter_rr_pkg::*;

  localparam int N   = 4;
  localparam int PKT = 2;
  localparam int SZ  = SIZE_DEF;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_req = '0;
  logic [N-1:0]    in_ack;
  logic [N*SZ-1:0] in_data = '0;
  logic            out_req;
  logic            out_ack = 1'b0;
  logic [SZ-1:0]   out_data;
  logic            lock_err;
  arb_state_e      dbg_state;
  logic [2:0]      dbg_ptr;
  logic [7:0]      dbg_cnt;

  always #5 clk = ~clk;

  flit_arbiter_rr #(.N_SRC(N), .PKT_FLITS(PKT), .SIZE(SZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .lock_err  (lock_err),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr),
    .dbg_cnt   (dbg_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*SZ-1:0] pk(input logic [SZ-1:0] d0, input logic [SZ-1:0] d1,
                                         input logic [SZ-1:0] d2, input logic [SZ-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Behavioural model: output slot, packet ownership, rotating priority
  bit            m_full, m_locked, m_err;
  int            m_owner, m_ptr, m_count, m_idle;
  logic [SZ-1:0] m_data;
  logic [N-1:0]  m_ack;
  logic [SZ-1:0] exp_q[$];

  task automatic model_reset();
    m_full = 0; m_locked = 0; m_err = 0;
    m_owner = 0; m_ptr = 0; m_count = 0; m_idle = 0;
    m_data = '0; m_ack = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int  cand;
    bit  was_locked;
    cand = -1;
    was_locked = m_locked;
    m_ack = '0;
    if (m_full) begin
      if (out_ack) m_full = 0;
    end else begin
      if (m_locked) begin
        if (in_req[m_owner]) cand = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_ptr + k) % N;
          if (cand < 0 && in_req[s]) cand = s;
        end
      end
      if (cand >= 0) begin
        m_data = in_data[cand*SZ +: SZ];
        m_full = 1;
        m_ack[cand] = 1'b1;
        exp_q.push_back(m_data);
        m_count++;
        if (m_count == PKT) begin
          m_locked = 0; m_ptr = (cand + 1) % N; m_count = 0;
        end else begin
          m_locked = 1; m_owner = cand;
        end
      end
    end
`ifdef FLIT_ARB_WATCHDOG_EN
    if (cand >= 0 || !was_locked) m_idle = 0;
    else if (!in_req[m_owner]) begin
      m_idle++;
      if (m_idle == ARB_WD_LIMIT) begin
        m_locked = 0; m_ptr = (m_owner + 1) % N; m_count = 0; m_err = 1; m_idle = 0;
      end
    end
`else
    if (was_locked) m_idle = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_req = '0; in_data = '0; out_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_req", out_req, 0);
    chk("reset in_ack", in_ack, 0);
    chk("reset out_data", out_data, 0);
    chk("reset lock_err", lock_err, 0);
    chk("reset ptr", dbg_ptr, 0);
    chk("reset cnt", dbg_cnt, 0);
    reset = 1'b1;
  endtask

  typedef struct {
    logic            first;
    logic [N-1:0]    req;
    logic [N*SZ-1:0] data;
    logic            oack;
    logic            exp_oreq;
    logic [SZ-1:0]   exp_odata;
    logic [N-1:0]    exp_ack;
    logic [2:0]      exp_ptr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // single source, then src1 vs src3 contention; out_ack held high
    tbl[0]  = '{1, 4'b0001, pk(16'h11, 0, 0, 0), 1, 1, 16'h11, 4'b0001, 3'd0};
    tbl[1]  = '{0, 4'b0001, pk(16'h22, 0, 0, 0), 1, 0, 16'h11, 4'b0000, 3'd0};
    tbl[2]  = '{0, 4'b0001, pk(16'h22, 0, 0, 0), 1, 1, 16'h22, 4'b0001, 3'd1};
    tbl[3]  = '{0, 4'b0000, pk(16'h22, 0, 0, 0), 1, 0, 16'h22, 4'b0000, 3'd1};
    tbl[4]  = '{1, 4'b1010, pk(0, 16'hA1, 0, 16'hC1), 1, 1, 16'hA1, 4'b0010, 3'd0};
    tbl[5]  = '{0, 4'b1010, pk(0, 16'hA2, 0, 16'hC1), 1, 0, 16'hA1, 4'b0000, 3'd0};
    tbl[6]  = '{0, 4'b1010, pk(0, 16'hA2, 0, 16'hC1), 1, 1, 16'hA2, 4'b0010, 3'd2};
    tbl[7]  = '{0, 4'b1000, pk(0, 0, 0, 16'hC1), 1, 0, 16'hA2, 4'b0000, 3'd2};
    tbl[8]  = '{0, 4'b1000, pk(0, 0, 0, 16'hC1), 1, 1, 16'hC1, 4'b1000, 3'd2};
    tbl[9]  = '{0, 4'b1000, pk(0, 0, 0, 16'hC2), 1, 0, 16'hC1, 4'b0000, 3'd2};
    tbl[10] = '{0, 4'b1000, pk(0, 0, 0, 16'hC2), 1, 1, 16'hC2, 4'b1000, 3'd0};
    tbl[11] = '{0, 4'b0000, pk(0, 0, 0, 16'hC2), 1, 0, 16'hC2, 4'b0000, 3'd0};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].first) do_reset();
      in_req = tbl[i].req; in_data = tbl[i].data; out_ack = tbl[i].oack;
      step();
      chk($sformatf("vec%0d out_req", i), out_req, tbl[i].exp_oreq);
      chk($sformatf("vec%0d out_data", i), out_data, tbl[i].exp_odata);
      chk($sformatf("vec%0d in_ack", i), in_ack, tbl[i].exp_ack);
      chk($sformatf("vec%0d ptr", i), dbg_ptr, tbl[i].exp_ptr);
    end

    // packet lock: src0 pauses mid-packet while src2 waits
    do_reset();
    in_req = 4'b0001; in_data = pk(16'h31, 0, 0, 0); out_ack = 1'b1;
    step();
    chk("lock first ack", in_ack, 4'b0001);
    in_req = 4'b0100; in_data = pk(0, 0, 16'h51, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lock hold ack", in_ack, 4'b0000);
      chk("lock hold state", dbg_state, ARB_LOCKED);
    end
    in_req = 4'b0101; in_data = pk(16'h32, 0, 16'h51, 0);
    step();
    chk("lock second ack", in_ack, 4'b0001);
    chk("lock second data", out_data, 16'h32);
    chk("lock release ptr", dbg_ptr, 3'd1);
    in_req = 4'b0100;
    step();
    step();
    chk("lock next src2 ack", in_ack, 4'b0100);
    chk("lock next src2 data", out_data, 16'h51);

    // backpressure: register stays full and stable with out_ack low
    do_reset();
    in_req = 4'b0011; in_data = pk(16'h41, 16'h61, 0, 0); out_ack = 1'b0;
    step();
    chk("bp capture ack", in_ack, 4'b0001);
    in_data = pk(16'h42, 16'h61, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp out_req", out_req, 1);
      chk("bp out_data", out_data, 16'h41);
      chk("bp in_ack", in_ack, 4'b0000);
    end
    out_ack = 1'b1;
    step();
    chk("bp drain", out_req, 0);
    step();
    chk("bp second flit", out_data, 16'h42);
    chk("bp second ack", in_ack, 4'b0001);
    in_req = 4'b0010; in_data = pk(0, 16'h61, 0, 0);
    step();
    step();
    chk("bp src1 flit", out_data, 16'h61);
    chk("bp src1 ack", in_ack, 4'b0010);

    // asynchronous reset mid-packet
    do_reset();
    in_req = 4'b1001; in_data = pk(16'h71, 0, 0, 16'h91); out_ack = 1'b0;
    step();
    chk("rst pre ack", in_ack, 4'b0001);
    in_data = pk(16'h72, 0, 0, 16'h91);
    #2 reset = 1'b0;
    #1;
    chk("rst async out_req", out_req, 0);
    chk("rst async in_ack", in_ack, 0);
    chk("rst async out_data", out_data, 0);
    chk("rst async state", dbg_state, ARB_UNLOCKED);
    chk("rst async cnt", dbg_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ack = 1'b1;
    step();
    chk("rst restart ack", in_ack, 4'b0001);
    chk("rst restart cnt", dbg_cnt, 1);
    chk("rst restart ptr", dbg_ptr, 0);
    in_data = pk(16'h73, 0, 0, 16'h91);
    step();
    step();
    chk("rst full packet ack", in_ack, 4'b0001);
    chk("rst full packet ptr", dbg_ptr, 3'd1);

    // lock watchdog: src2 idles after one flit while src3 requests
    do_reset();
    in_req = 4'b0100; in_data = pk(0, 0, 16'hB1, 0); out_ack = 1'b1;
    step();
    chk("wd first ack", in_ack, 4'b0100);
    in_req = 4'b1000; in_data = pk(0, 0, 0, 16'hD1);
`ifdef FLIT_ARB_WATCHDOG_EN
    for (int i = 0; i < ARB_WD_LIMIT - 1; i++) begin
      step();
      chk("wd idle no src3", in_ack[3], 0);
    end
    chk("wd not yet", lock_err, 0);
    step();
    chk("wd lock_err", lock_err, 1);
    chk("wd release ptr", dbg_ptr, 3'd3);
    step();
    chk("wd src3 granted", in_ack, 4'b1000);
    step();
    chk("wd sticky", lock_err, 1);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      chk("wd off no src3", in_ack[3], 0);
    end
    chk("wd off lock_err", lock_err, 0);
    chk("wd off still locked", dbg_state, ARB_LOCKED);
`endif

    // random traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (out_req && out_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd drain: got flit %0h expected none", out_data);
        end else begin
          chk("rnd drain data", out_data, exp_q.pop_front());
        end
      end
      model_step();
      step();
      chk("rnd out_req", out_req, m_full);
      chk("rnd out_data", out_data, m_data);
      chk("rnd in_ack", in_ack, m_ack);
      chk("rnd ptr", dbg_ptr, 3'(m_ptr));
      chk("rnd cnt", dbg_cnt, 8'(m_count));
      chk("rnd lock_err", lock_err, m_err);
      chk("rnd ack onehot", ($countones(in_ack) <= 1), 1);
      for (int i = 0; i < N; i++) begin
        if (in_ack[i]) begin
          if ($urandom_range(0, 3) != 0) in_data[i*SZ +: SZ] = SZ'($urandom);
          else in_req[i] = 1'b0;
        end else if (!in_req[i] && $urandom_range(0, 3) == 0) begin
          in_req[i] = 1'b1;
          in_data[i*SZ +: SZ] = SZ'($urandom);
        end
      end
      out_ack = ($urandom_range(0, 2) != 0);
    end
    chk("rnd queue depth", exp_q.size(), m_full);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
